ex_operand_stage: RTL and testbench

EX_OPERAND_STAGE -- requirements
Module: ex_operand_stage

---
 rtl/ex_operand_stage_pkg.sv | 27 ++
 rtl/forward_unit.sv | 40 ++++
 rtl/ex_operand_stage.sv | 118 +++++++++++
 tb/tb_ex_operand_stage.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/ex_operand_stage_pkg.sv
// Shared widths, forwarding-select encoding and ALU operation codes for the
// execute-stage operand path.
package ex_operand_stage_pkg;

  localparam int DEFAULT_DATA_WIDTH     = 32;
  localparam int DEFAULT_CONTROL_WIDTH  = 3;
  localparam int DEFAULT_REG_ADDR_WIDTH = 5;

  // Where an execute-stage operand is taken from.
  typedef enum logic [1:0] {
    FWD_NONE = 2'b00,
    FWD_WB   = 2'b01,
    FWD_MEM  = 2'b10
  } fwd_sel_e;

  // ALU operation codes as produced by the decoder.
  typedef enum logic [2:0] {
    ALU_ADD   = 3'b000,
    ALU_SUB   = 3'b001,
    ALU_AND   = 3'b010,
    ALU_OR    = 3'b011,
    ALU_XOR   = 3'b100,
    ALU_SLL   = 3'b101,
    ALU_PASSB = 3'b111
  } alu_op_e;

endpackage

// File: rtl/forward_unit.sv
// Hazard forwarding selection: picks the youngest in-flight producer of each
// execute-stage source register, never forwarding register x0.
module forward_unit
  import ex_operand_stage_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = DEFAULT_REG_ADDR_WIDTH
) (
  input  logic [REG_ADDR_WIDTH-1:0] rs1E_i,
  input  logic [REG_ADDR_WIDTH-1:0] rs2E_i,
  input  logic [REG_ADDR_WIDTH-1:0] rdM_i,
  input  logic                      regWriteM_i,
  input  logic [REG_ADDR_WIDTH-1:0] rdW_i,
  input  logic                      regWriteW_i,
  output logic [1:0]                forwardAE_o,
  output logic [1:0]                forwardBE_o
);

  logic memValid;
  logic wbValid;

  assign memValid = regWriteM_i && (rdM_i != '0);
  assign wbValid  = regWriteW_i && (rdW_i != '0);

  // Memory stage holds the newer value, so it is checked before writeback.
  always_comb begin
    forwardAE_o = FWD_NONE;
    forwardBE_o = FWD_NONE;
    if (memValid && (rdM_i == rs1E_i)) begin
      forwardAE_o = FWD_MEM;
    end else if (wbValid && (rdW_i == rs1E_i)) begin
      forwardAE_o = FWD_WB;
    end
    if (memValid && (rdM_i == rs2E_i)) begin
      forwardBE_o = FWD_MEM;
    end else if (wbValid && (rdW_i == rs2E_i)) begin
      forwardBE_o = FWD_WB;
    end
  end

endmodule

// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register with stall/flush control, plus the forwarding and
// ALU-source muxes that build the execute-stage operands.
module ex_operand_stage
  import ex_operand_stage_pkg::*;
#(
  parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
  parameter int CONTROL_WIDTH  = DEFAULT_CONTROL_WIDTH,
  parameter int REG_ADDR_WIDTH = DEFAULT_REG_ADDR_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      StallE,
  input  logic                      FlushE,
  input  logic [DATA_WIDTH-1:0]     RD1D,
  input  logic [DATA_WIDTH-1:0]     RD2D,
  input  logic [DATA_WIDTH-1:0]     ImmExtD,
  input  logic [DATA_WIDTH-1:0]     PCD,
  input  logic [REG_ADDR_WIDTH-1:0] Rs1D,
  input  logic [REG_ADDR_WIDTH-1:0] Rs2D,
  input  logic [REG_ADDR_WIDTH-1:0] RdD,
  input  logic [CONTROL_WIDTH-1:0]  ALUControlD,
  input  logic                      ALUSrcD,
  input  logic                      RegWriteD,
  input  logic                      MemWriteD,
  input  logic                      JumpD,
  input  logic                      BranchD,
  input  logic [1:0]                ResultSrcD,
  input  logic [DATA_WIDTH-1:0]     ALUResultM,
  input  logic [REG_ADDR_WIDTH-1:0] RdM,
  input  logic                      RegWriteM,
  input  logic [DATA_WIDTH-1:0]     ResultW,
  input  logic [REG_ADDR_WIDTH-1:0] RdW,
  input  logic                      RegWriteW,
  output logic [CONTROL_WIDTH-1:0]  ALUControlE,
  output logic [DATA_WIDTH-1:0]     SrcAE,
  output logic [DATA_WIDTH-1:0]     SrcBE,
  output logic [DATA_WIDTH-1:0]     WriteDataE,
  output logic [DATA_WIDTH-1:0]     PCE,
  output logic [DATA_WIDTH-1:0]     ImmExtE,
  output logic [REG_ADDR_WIDTH-1:0] RdE,
  output logic [REG_ADDR_WIDTH-1:0] Rs1E,
  output logic [REG_ADDR_WIDTH-1:0] Rs2E,
  output logic                      RegWriteE,
  output logic                      MemWriteE,
  output logic                      JumpE,
  output logic                      BranchE,
  output logic [1:0]                ResultSrcE,
  output logic [1:0]                ForwardAE,
  output logic [1:0]                ForwardBE
);

  // Every ID/EX field lives in one flat vector so a bubble is simply all zeros.
  localparam int IDEX_WIDTH = 4*DATA_WIDTH + 3*REG_ADDR_WIDTH + CONTROL_WIDTH + 7;

  logic [IDEX_WIDTH-1:0] idexLoad;
  logic [IDEX_WIDTH-1:0] idex_d;
  logic [IDEX_WIDTH-1:0] idex_q;
  logic [DATA_WIDTH-1:0] rd1E;
  logic [DATA_WIDTH-1:0] rd2E;
  logic                  aluSrcE;

  assign idexLoad = {RD1D, RD2D, ImmExtD, PCD, Rs1D, Rs2D, RdD, ALUControlD,
                     ALUSrcD, RegWriteD, MemWriteD, JumpD, BranchD, ResultSrcD};

  assign {rd1E, rd2E, ImmExtE, PCE, Rs1E, Rs2E, RdE, ALUControlE,
          aluSrcE, RegWriteE, MemWriteE, JumpE, BranchE, ResultSrcE} = idex_q;

  // Next ID/EX contents: flush beats stall, stall holds, otherwise load decode.
  always_comb begin
    idex_d = idex_q;
    if (FlushE) begin
      idex_d = '0;
    end else if (!StallE) begin
      idex_d = idexLoad;
    end
  end

  // ID/EX register; reset inserts a bubble regardless of stall or flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      idex_q <= '0;
    end else begin
      idex_q <= idex_d;
    end
  end

  forward_unit #(
    .REG_ADDR_WIDTH(REG_ADDR_WIDTH)
  ) u_forward_unit (
    .rs1E_i      (Rs1E),
    .rs2E_i      (Rs2E),
    .rdM_i       (RdM),
    .regWriteM_i (RegWriteM),
    .rdW_i       (RdW),
    .regWriteW_i (RegWriteW),
    .forwardAE_o (ForwardAE),
    .forwardBE_o (ForwardBE)
  );

  // Operand selection: forwarded values override stale register reads, then
  // the immediate may replace the second ALU operand.
  always_comb begin
    SrcAE      = rd1E;
    WriteDataE = rd2E;
    case (ForwardAE)
      FWD_WB:  SrcAE = ResultW;
      FWD_MEM: SrcAE = ALUResultM;
      default: SrcAE = rd1E;
    endcase
    case (ForwardBE)
      FWD_WB:  WriteDataE = ResultW;
      FWD_MEM: WriteDataE = ALUResultM;
      default: WriteDataE = rd2E;
    endcase
    SrcBE = aluSrcE ? ImmExtE : WriteDataE;
  end

endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed-vector bench for ex_operand_stage with hand-computed expectations.
module tb_ex_operand_stage;

  logic        clk;
  logic        rst;
  logic        StallE, FlushE;
  logic [31:0] RD1D, RD2D, ImmExtD, PCD;
  logic [4:0]  Rs1D, Rs2D, RdD;
  logic [2:0]  ALUControlD;
  logic        ALUSrcD, RegWriteD, MemWriteD, JumpD, BranchD;
  logic [1:0]  ResultSrcD;
  logic [31:0] ALUResultM;
  logic [4:0]  RdM;
  logic        RegWriteM;
  logic [31:0] ResultW;
  logic [4:0]  RdW;
  logic        RegWriteW;
  logic [2:0]  ALUControlE;
  logic [31:0] SrcAE, SrcBE, WriteDataE, PCE, ImmExtE;
  logic [4:0]  RdE, Rs1E, Rs2E;
  logic        RegWriteE, MemWriteE, JumpE, BranchE;
  logic [1:0]  ResultSrcE, ForwardAE, ForwardBE;

  int testsRun;
  int testsFailed;

  ex_operand_stage dut (
    .clk(clk), .rst(rst), .StallE(StallE), .FlushE(FlushE),
    .RD1D(RD1D), .RD2D(RD2D), .ImmExtD(ImmExtD), .PCD(PCD),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD), .ALUControlD(ALUControlD),
    .ALUSrcD(ALUSrcD), .RegWriteD(RegWriteD), .MemWriteD(MemWriteD),
    .JumpD(JumpD), .BranchD(BranchD), .ResultSrcD(ResultSrcD),
    .ALUResultM(ALUResultM), .RdM(RdM), .RegWriteM(RegWriteM),
    .ResultW(ResultW), .RdW(RdW), .RegWriteW(RegWriteW),
    .ALUControlE(ALUControlE), .SrcAE(SrcAE), .SrcBE(SrcBE),
    .WriteDataE(WriteDataE), .PCE(PCE), .ImmExtE(ImmExtE),
    .RdE(RdE), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .JumpE(JumpE),
    .BranchE(BranchE), .ResultSrcE(ResultSrcE),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE)
  );

  // Free-running clock, 10 time units per cycle.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Counts one comparison and reports it when observed differs from expected.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Advances one clock edge and settles just past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one decode-stage instruction onto the D inputs.
  task automatic applyStimulus(input logic [31:0] rd1, input logic [31:0] rd2,
                               input logic [31:0] imm, input logic [31:0] pc,
                               input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic [4:0] rd, input logic [2:0] aluCtl,
                               input logic aluSrc, input logic [4:0] ctlBits);
    RD1D        = rd1;
    RD2D        = rd2;
    ImmExtD     = imm;
    PCD         = pc;
    Rs1D        = rs1;
    Rs2D        = rs2;
    RdD         = rd;
    ALUControlD = aluCtl;
    ALUSrcD     = aluSrc;
    {RegWriteD, MemWriteD, JumpD, BranchD} = ctlBits[4:1];
    ResultSrcD  = {ctlBits[0], 1'b0};
  endtask

  // Clears memory/writeback forwarding sources.
  task automatic clearForwarding();
    ALUResultM = '0; RdM = '0; RegWriteM = 1'b0;
    ResultW    = '0; RdW = '0; RegWriteW = 1'b0;
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    rst    = 1'b1;
    StallE = 1'b0;
    FlushE = 1'b0;
    applyStimulus(32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 3'b000, 1'b0, 5'b00000);
    clearForwarding();
    tick();
    tick();

    // Reset state
    checkOutput("rst_RegWriteE", {31'd0, RegWriteE}, 32'd0);
    checkOutput("rst_ALUControlE", {29'd0, ALUControlE}, 32'd0);
    checkOutput("rst_PCE", PCE, 32'd0);
    checkOutput("rst_ForwardAE", {30'd0, ForwardAE}, 32'd0);
    RegWriteM = 1'b1;
    RegWriteW = 1'b1;
    #1;
    checkOutput("x0_ForwardAE", {30'd0, ForwardAE}, 32'd0);
    checkOutput("x0_ForwardBE", {30'd0, ForwardBE}, 32'd0);
    clearForwarding();
    rst = 1'b0;

    // Plain load, no hazards
    applyStimulus(32'd5, 32'd7, 32'h0, 32'h40, 5'd1, 5'd2, 5'd4, 3'b000, 1'b0, 5'b00000);
    tick();
    checkOutput("load_SrcAE", SrcAE, 32'd5);
    checkOutput("load_SrcBE", SrcBE, 32'd7);
    checkOutput("load_ALUControlE", {29'd0, ALUControlE}, 32'd0);
    applyStimulus(32'd1, 32'd2, 32'h0, 32'h44, 5'd1, 5'd2, 5'd4, 3'b100, 1'b0, 5'b00000);
    tick();
    checkOutput("load_ALUControlE_xor", {29'd0, ALUControlE}, 32'd4);

    // Rs1 forwarding: memory beats writeback, then writeback alone, then none
    applyStimulus(32'h55, 32'h66, 32'h0, 32'h48, 5'd3, 5'd12, 5'd4, 3'b000, 1'b0, 5'b00000);
    tick();
    ALUResultM = 32'h10; RdM = 5'd3; RegWriteM = 1'b1;
    ResultW    = 32'h20; RdW = 5'd3; RegWriteW = 1'b1;
    #1;
    checkOutput("fwdA_mem_sel", {30'd0, ForwardAE}, 32'd2);
    checkOutput("fwdA_mem_SrcAE", SrcAE, 32'h10);
    RegWriteM = 1'b0;
    #1;
    checkOutput("fwdA_wb_sel", {30'd0, ForwardAE}, 32'd1);
    checkOutput("fwdA_wb_SrcAE", SrcAE, 32'h20);
    RegWriteW = 1'b0;
    #1;
    checkOutput("fwdA_none_SrcAE", SrcAE, 32'h55);
    clearForwarding();

    // Rs2 = x0 is never forwarded
    applyStimulus(32'h1, 32'd9, 32'h0, 32'h4C, 5'd1, 5'd0, 5'd4, 3'b000, 1'b0, 5'b00000);
    tick();
    ALUResultM = 32'h10; RdM = 5'd0; RegWriteM = 1'b1;
    #1;
    checkOutput("x0B_sel", {30'd0, ForwardBE}, 32'd0);
    checkOutput("x0B_WriteDataE", WriteDataE, 32'd9);
    checkOutput("x0B_SrcBE", SrcBE, 32'd9);
    clearForwarding();

    // Immediate operand with Rs2 forwarded for the store data
    applyStimulus(32'h1, 32'h77, 32'hFFFF_FFFC, 32'h50, 5'd1, 5'd6, 5'd4, 3'b000, 1'b1, 5'b00000);
    tick();
    ResultW = 32'd4; RdW = 5'd6; RegWriteW = 1'b1;
    #1;
    checkOutput("imm_ForwardBE", {30'd0, ForwardBE}, 32'd1);
    checkOutput("imm_SrcBE", SrcBE, 32'hFFFF_FFFC);
    checkOutput("imm_WriteDataE", WriteDataE, 32'd4);
    ALUResultM = 32'h99; RdM = 5'd6; RegWriteM = 1'b1;
    #1;
    checkOutput("immMem_ForwardBE", {30'd0, ForwardBE}, 32'd2);
    checkOutput("immMem_WriteDataE", WriteDataE, 32'h99);
    clearForwarding();

    // Stall holds for two cycles, then flush+stall inserts a bubble
    applyStimulus(32'h11, 32'h22, 32'h33, 32'h100, 5'd7, 5'd8, 5'd9, 3'b001, 1'b0, 5'b11111);
    tick();
    checkOutput("valid_RegWriteE", {31'd0, RegWriteE}, 32'd1);
    applyStimulus(32'hAA, 32'hBB, 32'hCC, 32'h200, 5'd10, 5'd11, 5'd12, 3'b010, 1'b1, 5'b00000);
    StallE = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checkOutput($sformatf("stall%0d_PCE", i), PCE, 32'h100);
      checkOutput($sformatf("stall%0d_RdE", i), {27'd0, RdE}, 32'd9);
      checkOutput($sformatf("stall%0d_SrcAE", i), SrcAE, 32'h11);
      checkOutput($sformatf("stall%0d_ctl", i),
                  {25'd0, RegWriteE, MemWriteE, JumpE, BranchE, ResultSrcE, 1'b0},
                  32'b1111100);
    end
    FlushE = 1'b1;
    tick();
    checkOutput("bubble_PCE", PCE, 32'd0);
    checkOutput("bubble_ImmExtE", ImmExtE, 32'd0);
    checkOutput("bubble_idx", {17'd0, RdE, Rs1E, Rs2E}, 32'd0);
    checkOutput("bubble_ctl", {26'd0, RegWriteE, MemWriteE, JumpE, BranchE, ResultSrcE}, 32'd0);
    checkOutput("bubble_ALUControlE", {29'd0, ALUControlE}, 32'd0);
    checkOutput("bubble_SrcAE", SrcAE, 32'd0);
    checkOutput("bubble_WriteDataE", WriteDataE, 32'd0);
    FlushE = 1'b0;
    StallE = 1'b0;

    // Stall released: decode inputs are loaded again
    tick();
    checkOutput("release_PCE", PCE, 32'h200);
    checkOutput("release_SrcBE", SrcBE, 32'hCC);

    // Reset overrides a stall
    applyStimulus(32'h1, 32'h2, 32'h3, 32'h300, 5'd1, 5'd2, 5'd3, 3'b011, 1'b0, 5'b10000);
    StallE = 1'b1;
    rst    = 1'b1;
    tick();
    checkOutput("rstStall_RegWriteE", {31'd0, RegWriteE}, 32'd0);
    checkOutput("rstStall_ALUControlE", {29'd0, ALUControlE}, 32'd0);
    checkOutput("rstStall_PCE", PCE, 32'd0);
    rst    = 1'b0;
    StallE = 1'b0;
    tick();
    checkOutput("postRst_PCE", PCE, 32'h300);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
